// File: rtl/mastermind_ctrl.sv
// Mastermind round controller: seeds the PRNG, latches the secret, scores guesses, counts tries.
// Scores arrive 10 cycles after a guess is accepted; guess_ready stays low while scoring, so callers must wait.
module mastermind_ctrl #(
    parameter int MAX_TRIES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        prng_rst,
    input  logic [2:0]  code0,
    input  logic [2:0]  code1,
    input  logic [2:0]  code2,
    input  logic [2:0]  code3,
    input  logic        guess_valid,
    input  logic [11:0] guess,
    output logic        guess_ready,
    output logic        score_valid,
    output logic [2:0]  exact,
    output logic [2:0]  partial,
    output logic [3:0]  tries,
    output logic        win,
    output logic        lose,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_SEED, S_LATCH, S_READY, S_EXACT, S_COUNT, S_REPORT, S_WON, S_LOST
    } state_t;

    state_t      state_q;
    logic [11:0] secret_q, guess_q;
    logic [2:0]  color_q, acc_q, acc_d, exact_cnt, g_cnt, s_cnt;
    logic [2:0]  exact_q, partial_q;
    logic [3:0]  tries_q;
    logic        prng_rst_q, guess_ready_q, score_valid_q, win_q, lose_q, busy_q;

    // acc_d folds in min(#guess digits, #secret digits) of the current colour.
    always_comb begin
        exact_cnt = '0;
        g_cnt     = '0;
        s_cnt     = '0;
        for (int i = 0; i < 4; i++) begin
            if (guess_q[3*i +: 3] == secret_q[3*i +: 3]) exact_cnt = exact_cnt + 3'd1;
            if (guess_q[3*i +: 3] == color_q)            g_cnt     = g_cnt + 3'd1;
            if (secret_q[3*i +: 3] == color_q)           s_cnt     = s_cnt + 3'd1;
        end
        acc_d = acc_q + ((g_cnt < s_cnt) ? g_cnt : s_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            secret_q      <= '0;
            guess_q       <= '0;
            color_q       <= '0;
            acc_q         <= '0;
            exact_q       <= '0;
            partial_q     <= '0;
            tries_q       <= '0;
            prng_rst_q    <= 1'b0;
            guess_ready_q <= 1'b0;
            score_valid_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            prng_rst_q    <= 1'b0;
            score_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WON, S_LOST, S_READY: begin
                    if (start) begin
                        state_q       <= S_SEED;
                        tries_q       <= '0;
                        exact_q       <= '0;
                        partial_q     <= '0;
                        win_q         <= 1'b0;
                        lose_q        <= 1'b0;
                        prng_rst_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        guess_ready_q <= 1'b0;
                    end else if (state_q == S_READY && guess_valid) begin
                        guess_q       <= guess;
                        state_q       <= S_EXACT;
                        guess_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                S_SEED: state_q <= S_LATCH;
                S_LATCH: begin
                    secret_q      <= {code3, code2, code1, code0};
                    state_q       <= S_READY;
                    busy_q        <= 1'b0;
                    guess_ready_q <= 1'b1;
                end
                S_EXACT: begin
                    exact_q <= exact_cnt;
                    color_q <= '0;
                    acc_q   <= '0;
                    state_q <= S_COUNT;
                end
                S_COUNT: begin
                    acc_q   <= acc_d;
                    color_q <= color_q + 3'd1;
                    if (color_q == 3'd7) begin
                        partial_q     <= acc_d - exact_q;
                        score_valid_q <= 1'b1;
                        state_q       <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    tries_q <= tries_q + 4'd1;
                    busy_q  <= 1'b0;
                    if (exact_q == 3'd4) begin
                        state_q <= S_WON;
                        win_q   <= 1'b1;
                    end else if (tries_q + 4'd1 == 4'(MAX_TRIES)) begin
                        state_q <= S_LOST;
                        lose_q  <= 1'b1;
                    end else begin
                        state_q       <= S_READY;
                        guess_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign prng_rst    = prng_rst_q;
    assign guess_ready = guess_ready_q;
    assign score_valid = score_valid_q;
    assign exact       = exact_q;
    assign partial     = partial_q;
    assign tries       = tries_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mastermind_ctrl.sv
// Bench for mastermind_ctrl: stubbed PRNG, scoreboard of expected scores, monitor on score_valid.
module tb_mastermind_ctrl;
    localparam int MAXT = 3;

    logic        clk = 1'b0;
    logic        rst, start, prng_rst, guess_valid, guess_ready, score_valid, win, lose, busy;
    logic [2:0]  code0 = '0, code1 = '0, code2 = '0, code3 = '0;
    logic [2:0]  exact, partial;
    logic [11:0] guess;
    logic [3:0]  tries;

    mastermind_ctrl #(.MAX_TRIES(MAXT)) dut (
        .clk(clk), .rst(rst), .start(start), .prng_rst(prng_rst),
        .code0(code0), .code1(code1), .code2(code2), .code3(code3),
        .guess_valid(guess_valid), .guess(guess), .guess_ready(guess_ready),
        .score_valid(score_valid), .exact(exact), .partial(partial), .tries(tries),
        .win(win), .lose(lose), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ex;
        logic [2:0] pa;
        logic [3:0] tr;
        logic       w;
        logic       l;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        post_item;
    bit          post_pending = 0;
    bit          last_done = 0;
    int          n_pass = 0, n_total = 0, cyc = 0, tries_m = 0, sv_seen = 0;
    logic [11:0] next_secret = '0, cur_secret = '0;

    // PRNG stub: a new code appears on the edge that samples prng_rst.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (prng_rst) {code3, code2, code1, code0} <= next_secret;
    end

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference scoring: pair exact positions first, then greedily pair leftovers.
    task automatic score(input logic [11:0] s, input logic [11:0] g, output int ex, output int pa);
        bit su[4];
        bit gu[4];
        bit found;
        ex = 0;
        pa = 0;
        for (int i = 0; i < 4; i++) begin
            su[i] = (g[3*i +: 3] == s[3*i +: 3]);
            gu[i] = su[i];
            if (su[i]) ex++;
        end
        for (int i = 0; i < 4; i++) begin
            found = 0;
            if (!gu[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (!found && !su[j] && g[3*i +: 3] == s[3*j +: 3]) begin
                        su[j] = 1;
                        found = 1;
                        pa++;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (post_pending) begin
            chk("post_tries", tries, post_item.tr);
            chk("post_win", win, post_item.w);
            chk("post_lose", lose, post_item.l);
            chk("post_ready", guess_ready, !(post_item.w || post_item.l));
            post_pending = 0;
        end
        if (score_valid) begin
            sv_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_score_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("exact", exact, mon_e.ex);
                chk("partial", partial, mon_e.pa);
                chk("score_latency_cycle", cyc, mon_e.cyc);
                post_item    = mon_e;
                post_pending = 1;
            end
        end
    end

    function automatic logic [11:0] rand_code(input bit dup);
        logic [11:0] c;
        for (int i = 0; i < 4; i++)
            c[3*i +: 3] = dup ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
        return c;
    endfunction

    function automatic logic [11:0] wrong_guess();
        logic [11:0] g;
        g = rand_code($urandom_range(0, 1) == 1);
        while (g == cur_secret) g = rand_code(0);
        return g;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (guess_ready) ok = 1;
            else @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    // Called at a negedge; optionally presents a guess in the same cycle as start.
    task automatic start_round(input logic [11:0] sec, input bit with_guess);
        next_secret = sec;
        start = 1;
        if (with_guess) begin
            guess_valid = 1;
            guess       = cur_secret;
        end
        @(negedge clk);
        start       = 0;
        guess_valid = 0;
        chk("seed_prng_rst", prng_rst, 1);
        chk("seed_busy", busy, 1);
        chk("seed_tries", tries, 0);
        chk("seed_exact", exact, 0);
        chk("seed_ready", guess_ready, 0);
        chk("seed_winlose", {win, lose}, 0);
        @(negedge clk);
        chk("latch_prng_rst", prng_rst, 0);
        chk("latch_ready", guess_ready, 0);
        @(negedge clk);
        chk("ready_rise", guess_ready, 1);
        chk("ready_busy", busy, 0);
        cur_secret = sec;
        tries_m    = 0;
    endtask

    task automatic send_guess(input logic [11:0] g);
        bit   ok;
        int   ex, pa;
        exp_t e;
        wait_ready(ok);
        if (ok) begin
            score(cur_secret, g, ex, pa);
            tries_m++;
            e.ex  = 3'(ex);
            e.pa  = 3'(pa);
            e.tr  = 4'(tries_m);
            e.w   = (ex == 4);
            e.l   = !e.w && (tries_m == MAXT);
            e.cyc = cyc + 10;
            last_done = e.w || e.l;
            sb.push_back(e);
            guess_valid = 1;
            guess       = g;
            @(negedge clk);
            guess_valid = 0;
            ok = 0;
            for (int i = 0; i < 30 && !ok; i++) begin
                @(negedge clk);
                if (sb.size() == 0 && !post_pending) ok = 1;
            end
            if (!ok) chk("score_timeout", 0, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_total);
        $fatal(1);
    end

    initial begin
        bit ok;
        int snap;
        rst = 1; start = 0; guess_valid = 0; guess = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 1) rst = 0;
            chk("reset_idle_outputs",
                {prng_rst, guess_ready, score_valid, exact, partial, tries, win, lose, busy}, 0);
        end

        start_round({3'd3, 3'd2, 3'd1, 3'd0}, 0);
        send_guess({3'd0, 3'd1, 3'd2, 3'd3});
        send_guess({3'd0, 3'd0, 3'd0, 3'd0});
        chk("tries_before_restart", tries, 2);
        // Restart from READY with a winning guess offered in the same cycle; start must win.
        start_round({3'd5, 3'd1, 3'd2, 3'd1}, 1);
        send_guess({3'd1, 3'd1, 3'd1, 3'd1});
        send_guess({3'd1, 3'd5, 3'd1, 3'd2});
        send_guess({3'd5, 3'd1, 3'd2, 3'd1});
        chk("win_level", win, 1);

        start_round(rand_code(0), 0);
        for (int k = 0; k < 3; k++) send_guess(wrong_guess());
        chk("lose_level", lose, 1);
        guess_valid = 1;
        guess       = cur_secret;
        repeat (12) @(negedge clk);
        guess_valid = 0;
        chk("ignored_guess_tries", tries, 3);
        chk("ignored_guess_lose", lose, 1);
        chk("ignored_guess_ready", guess_ready, 0);

        for (int r = 0; r < 8; r++) begin
            start_round(rand_code($urandom_range(0, 1) == 1), 0);
            last_done = 0;
            for (int k = 0; k < 3 && !last_done; k++)
                send_guess(($urandom_range(0, 3) == 0) ? cur_secret : rand_code($urandom_range(0, 1) == 1));
        end

        start_round(rand_code(0), 0);
        wait_ready(ok);
        guess_valid = 1;
        guess       = wrong_guess();
        @(negedge clk);
        guess_valid = 0;
        repeat (3) @(negedge clk);
        chk("count_busy", busy, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_outputs",
            {prng_rst, guess_ready, score_valid, exact, partial, tries, win, lose, busy}, 0);
        snap = sv_seen;
        repeat (15) @(negedge clk);
        chk("no_score_after_rst", sv_seen - snap, 0);
        chk("idle_after_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
